// File: rtl/spi_target.sv
// SPI mode-0 target endpoint: oversamples SCLK/SS/MOSI in the clk domain and exchanges
// one byte or one 32-bit word per frame (bytes MSbit first, words LSByte first).
module spi_target (
  input  logic        clk,
  input  logic        rst,
  input  logic        wide,
  input  logic        SS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        misoEn,
  input  logic [31:0] dataTx,
  input  logic        load,
  output logic        txe,
  output logic [31:0] dataRx,
  output logic        rdy,
  input  logic        ack,
  output logic        ovf
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  ss_sync_q, ss_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] txbuf_q, txbuf_d;
  logic [31:0] data_rx_q, data_rx_d;
  logic        txe_q, txe_d;
  logic        rdy_q, rdy_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        wmode_q, wmode_d;
  logic        inb_q, inb_d;

  logic        sclk_rise, sclk_fall, ss_fall, ss_high;
  logic        last_bit, reload, eof;
  logic [31:0] shifted;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_high   = ss_sync_q[1];

  // Each byte shifts left; in word mode byte n+1's MSbit feeds byte n, so after 32 shifts
  // the first received byte sits in the least significant byte.
  assign shifted = {shreg_q[30:24], inb_q, shreg_q[22:16], shreg_q[31], shreg_q[14:8],
                    shreg_q[23], shreg_q[6:0], (wmode_q ? shreg_q[15] : inb_q)};
  assign last_bit = wmode_q ? (bitcnt_q == 5'd31) : (bitcnt_q == 5'd7);

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    ss_sync_d   = {ss_sync_q[1:0], SS};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    shreg_d     = shreg_q;
    txbuf_d     = txbuf_q;
    data_rx_d   = data_rx_q;
    txe_d       = txe_q;
    rdy_d       = rdy_q;
    ovf_d       = ovf_q;
    bitcnt_d    = bitcnt_q;
    wmode_d     = wmode_q;
    inb_d       = inb_q;
    reload      = 1'b0;
    eof         = 1'b0;

    case (state_q)
      StIdle: begin
        if (ss_fall) begin
          reload   = 1'b1;
          wmode_d  = wide;
          bitcnt_d = 5'd0;
          state_d  = StActive;
        end
      end
      StActive: begin
        if (ss_high) begin
          state_d  = StIdle;
          bitcnt_d = 5'd0;
        end else if (sclk_rise) begin
          inb_d = mosi_sync_q[1];
        end else if (sclk_fall) begin
          shreg_d = shifted;
          if (last_bit) begin
            eof      = 1'b1;
            reload   = 1'b1;
            bitcnt_d = 5'd0;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      txbuf_d = dataTx;
      txe_d   = 1'b0;
    end

    // A load coinciding with a reload bypasses the buffer straight into the shifter.
    if (reload) begin
      shreg_d = load ? dataTx : txbuf_q;
      txbuf_d = '1;
      txe_d   = 1'b1;
    end

    if (eof) begin
      data_rx_d = wmode_q ? shifted : {24'b0, shifted[7:0]};
      rdy_d     = 1'b1;
      if (!ack) begin
        ovf_d = ovf_q | rdy_q;
      end
    end else if (ack) begin
      rdy_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      shreg_q     <= '1;
      txbuf_q     <= '1;
      data_rx_q   <= '0;
      txe_q       <= 1'b1;
      rdy_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bitcnt_q    <= 5'd0;
      wmode_q     <= 1'b0;
      inb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      shreg_q     <= shreg_d;
      txbuf_q     <= txbuf_d;
      data_rx_q   <= data_rx_d;
      txe_q       <= txe_d;
      rdy_q       <= rdy_d;
      ovf_q       <= ovf_d;
      bitcnt_q    <= bitcnt_d;
      wmode_q     <= wmode_d;
      inb_q       <= inb_d;
    end
  end

  assign MISO   = (state_q == StActive) ? shreg_q[7] : 1'b1;
  assign misoEn = ~ss_sync_q[1];
  assign txe    = txe_q;
  assign dataRx = data_rx_q;
  assign rdy    = rdy_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an initiator driver feeds frames, scoreboards check the MISO
// stream and each received frame against a frame-level model.
module tb_spi_target;

  logic        clk, rst, wide, SS, SCLK, MOSI, load, ack;
  logic [31:0] dataTx;
  logic        MISO, misoEn, txe, rdy, ovf;
  logic [31:0] dataRx;

  spi_target dut (
    .clk    (clk),
    .rst    (rst),
    .wide   (wide),
    .SS     (SS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .misoEn (misoEn),
    .dataTx (dataTx),
    .load   (load),
    .txe    (txe),
    .dataRx (dataRx),
    .rdy    (rdy),
    .ack    (ack),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [31:0] val;
  } tx_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  int checks = 0;
  int errors = 0;

  // Frame-level model: pending transmit word, receive flags, current dataRx.
  logic [31:0] m_tx;
  logic        m_rdy, m_ovf;
  logic [31:0] m_last;

  logic [31:0] fr_mosi   [4];
  logic [31:0] fr_ld_val [4];
  bit          fr_load   [4];
  bit          fr_ack    [4];

  int          miso_n;
  logic [31:0] miso_acc;
  logic        mon_rdy_prev;
  logic [31:0] mon_rx_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Initiator view of MISO: bits sampled on SCLK rise, reassembled into a frame value.
  initial begin : miso_mon
    tx_exp_t e;
    miso_n   = 0;
    miso_acc = '0;
    forever begin
      @(posedge SCLK or posedge SS);
      if (SS === 1'b1) begin
        miso_n   = 0;
        miso_acc = '0;
      end else if (misoEn === 1'b1) begin
        miso_acc[8*(miso_n/8) + 7 - (miso_n%8)] = MISO;
        miso_n++;
        if (tx_q.size() != 0 && miso_n == tx_q[0].nb) begin
          e = tx_q.pop_front();
          check("miso_frame", miso_acc & (e.nb == 32 ? 32'hFFFF_FFFF : 32'hFF), e.val);
          miso_n   = 0;
          miso_acc = '0;
        end else if (miso_n == 32) begin
          miso_n = 0;
        end
      end
    end
  end

  // A completed frame shows up as rdy rising or dataRx changing while rdy is held.
  initial begin : rx_mon
    rx_exp_t e;
    mon_rdy_prev = 1'b0;
    mon_rx_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rdy === 1'b1 && (!mon_rdy_prev || dataRx !== mon_rx_prev)) begin
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got %h expected no frame", dataRx);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", dataRx, e.data);
          check("rx_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
      mon_rdy_prev = rdy;
      mon_rx_prev  = dataRx;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [31:0] v);
    dataTx = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_tx = v;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_reset();
    m_tx   = '1;
    m_rdy  = 1'b0;
    m_ovf  = 1'b0;
    m_last = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_txe", 32'(txe), 32'd1);
    check("rst_dataRx", dataRx, 32'd0);
    check("rst_misoEn", 32'(misoEn), 32'd0);
    check("rst_MISO", 32'(MISO), 32'd1);
  endtask

  // mode 0: full frames; 1: SS raised after abort_bit bits; 2: reset after abort_bit bits.
  task automatic session(input logic w, input int nfr, input int mode, input int abort_bit,
                         input bit ack_end);
    int          nb, b;
    logic [31:0] mask, txv, rxv;
    tx_exp_t     te;
    rx_exp_t     re;
    nb   = w ? 32 : 8;
    mask = w ? 32'hFFFF_FFFF : 32'hFF;
    wide = w;
    if (fr_load[0]) do_load(fr_ld_val[0]);
    SS = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nfr; k++) begin
      txv  = m_tx & mask;
      m_tx = '1;
      if (mode == 0) begin
        te.nb  = nb;
        te.val = txv;
        tx_q.push_back(te);
      end
      for (int j = 0; j < nb; j++) begin
        b    = 8*(j/8) + 7 - (j%8);
        MOSI = fr_mosi[k][b];
        if (j == 1 && k + 1 < nfr && fr_load[k+1]) do_load(fr_ld_val[k+1]);
        if (j == 3 && fr_ack[k]) do_ack();
        repeat (4) @(negedge clk);
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
        if (mode != 0 && j + 1 == abort_bit) break;
      end
      if (mode == 1) begin
        SS = 1'b1;
        repeat (6) @(negedge clk);
        return;
      end
      if (mode == 2) begin
        rst = 1'b0;
        SS  = 1'b1;
        return;
      end
      rxv = fr_mosi[k] & mask;
      if (!(ack_end && k == nfr - 1)) m_ovf = m_ovf | m_rdy;
      m_rdy   = 1'b1;
      m_last  = rxv;
      re.data = rxv;
      re.ovf  = m_ovf;
      rx_q.push_back(re);
    end
    if (ack_end) begin
      repeat (2) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_frames();
    for (int k = 0; k < 4; k++) begin
      fr_mosi[k]   = '0;
      fr_ld_val[k] = '0;
      fr_load[k]   = 1'b0;
      fr_ack[k]    = 1'b0;
    end
  endtask

  initial begin : stim
    logic        w;
    int          nfr, ab, abit;
    logic [31:0] mask, v, prev;
    bit          ae;

    rst = 1'b0; wide = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    load = 1'b0; ack = 1'b0; dataTx = '0;
    model_reset();
    clear_frames();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Byte exchange
    do_load(32'h0000_00A5);
    check("txe_after_load", 32'(txe), 32'd0);
    fr_mosi[0] = 32'h3C;
    session(1'b0, 1, 0, 0, 1'b0);
    check("byte_rdy", 32'(rdy), 32'd1);
    check("byte_txe", 32'(txe), 32'd1);
    do_ack();
    check("ack_rdy", 32'(rdy), 32'd0);

    // Word ordering
    clear_frames();
    fr_load[0] = 1'b1; fr_ld_val[0] = 32'h4433_2211; fr_mosi[0] = 32'hDDCC_BBAA;
    session(1'b1, 1, 0, 0, 1'b0);
    do_ack();

    // Overrun
    clear_frames();
    fr_mosi[0] = 32'h01; fr_mosi[1] = 32'h02;
    session(1'b0, 2, 0, 0, 1'b0);
    check("ovr_rdy", 32'(rdy), 32'd1);
    check("ovr_ovf", 32'(ovf), 32'd1);
    check("ovr_dataRx", dataRx, 32'h02);
    do_ack();
    check("ovr_ack_rdy", 32'(rdy), 32'd0);
    check("ovr_ack_ovf", 32'(ovf), 32'd0);

    // Underrun and continuity
    clear_frames();
    fr_load[0] = 1'b1; fr_ld_val[0] = 32'h5A; fr_mosi[0] = 32'h11; fr_mosi[1] = 32'h22;
    session(1'b0, 2, 0, 0, 1'b0);
    check("undr_txe", 32'(txe), 32'd1);
    do_ack();

    // Abort after 5 bits, then a clean frame
    clear_frames();
    fr_mosi[0] = 32'h99;
    session(1'b0, 1, 1, 5, 1'b0);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_dataRx", dataRx, 32'h22);
    check("abort_MISO", 32'(MISO), 32'd1);
    check("abort_misoEn", 32'(misoEn), 32'd0);
    fr_mosi[0] = 32'h81;
    session(1'b0, 1, 0, 0, 1'b0);

    // ack colliding with end of frame while rdy=1
    fr_mosi[0] = 32'h7E;
    session(1'b0, 1, 0, 0, 1'b1);
    check("coll_rdy", 32'(rdy), 32'd1);
    check("coll_ovf", 32'(ovf), 32'd0);

    // Reset in the middle of a word frame
    clear_frames();
    fr_load[0] = 1'b1; fr_ld_val[0] = 32'h1234_5678; fr_mosi[0] = 32'hCAFE_F00D;
    session(1'b1, 1, 2, 10, 1'b0);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);

    // Randomized sessions
    for (int s = 0; s < 24; s++) begin
      w    = 1'($urandom_range(0, 1));
      nfr  = int'($urandom_range(1, 3));
      ab   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      mask = w ? 32'hFFFF_FFFF : 32'hFF;
      ae   = 1'($urandom_range(0, 3) == 0);
      prev = m_last;
      for (int k = 0; k < 4; k++) begin
        v = $urandom & mask;
        if (v == prev) v = v ^ 32'h1;
        fr_mosi[k]   = v;
        prev         = v;
        fr_ld_val[k] = $urandom;
        fr_load[k]   = 1'($urandom_range(0, 1));
        fr_ack[k]    = 1'($urandom_range(0, 3) == 0);
      end
      if (ab != 0) begin
        abit = int'($urandom_range(1, w ? 31 : 7));
        session(w, 1, 1, abit, 1'b0);
        check("rand_abort_dataRx", dataRx, m_last);
        check("rand_abort_rdy", 32'(rdy), 32'(m_rdy));
      end else begin
        session(w, nfr, 0, 0, ae);
        check("rand_ovf", 32'(ovf), 32'(m_ovf));
      end
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    repeat (20) @(negedge clk);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
